// File: rtl/fft_frame_buffer.sv
// Single-frame sample buffer between the window stage and the FFT.
// Fills DEPTH samples, locks, then streams them out in natural or bit-reversed order.
module fft_frame_buffer #(
    parameter int DW      = 14,
    parameter int DEPTH   = 1024,
    parameter bit BIT_REV = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wren,
    input  logic [DW-1:0]                wdata,
    input  logic                         rden,
    output logic [DW-1:0]                rdata,
    output logic                         rvalid,
    output logic                         rlast,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic          wr_en;
    logic          rd_en;
    logic          last_wr;
    logic          last_rd;
    logic [AW-1:0] raddr;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // clr wins over any write or read in the same cycle
    always_comb begin
        wr_en   = (state == FILL) && wren && !clr;
        rd_en   = (state == DRAIN) && rden && !rd_ptr[AW] && !clr;
        last_wr = (wr_ptr == LAST_IDX);
        last_rd = (rd_ptr == LAST_IDX);
        raddr   = BIT_REV ? bitrev(rd_ptr[AW-1:0]) : rd_ptr[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Output register of the RAM; holds its value across clr and idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            overflow <= 1'b0;
        end else if (clr) begin
            state    <= FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rvalid <= rd_en;
            rlast  <= rd_en && last_rd;
            unique case (state)
                FILL: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (last_wr) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wren) begin
                        overflow <= 1'b1;
                    end
                    if (rd_en) begin
                        if (last_rd) begin
                            state  <= FILL;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        count = wr_ptr - rd_ptr;
        empty = (count == '0);
        full  = (state == DRAIN);
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: a 1024-deep natural-order and an 8-deep bit-reversed
// instance share one stimulus stream and are compared each cycle to a frame-level model.
module tb_fft_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [13:0] wdata = '0;

    logic [13:0] rdata_n, rdata_r;
    logic        rvalid_n, rvalid_r;
    logic        rlast_n, rlast_r;
    logic        full_n, full_r;
    logic        empty_n, empty_r;
    logic [10:0] count_n;
    logic [3:0]  count_r;
    logic        ovf_n, ovf_r;

    always #5 clk = ~clk;

    fft_frame_buffer #(.DW(14), .DEPTH(1024), .BIT_REV(1'b0)) u_nat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .wdata(wdata),
        .rden(rden), .rdata(rdata_n), .rvalid(rvalid_n), .rlast(rlast_n),
        .full(full_n), .empty(empty_n), .count(count_n), .overflow(ovf_n)
    );

    fft_frame_buffer #(.DW(14), .DEPTH(8), .BIT_REV(1'b1)) u_rev (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .wdata(wdata),
        .rden(rden), .rdata(rdata_r), .rvalid(rvalid_r), .rlast(rlast_r),
        .full(full_r), .empty(empty_r), .count(count_r), .overflow(ovf_r)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level model: index 0 = natural 1024, index 1 = bit-reversed 8
    int frame [2][1024];
    int order [2][1024];
    int nfill [2];
    int nrd   [2];
    int e_rdata [2];
    bit drain [2];
    bit ovf   [2];
    bit e_rv  [2];
    bit e_rl  [2];

    function automatic int dep(input int m);
        return (m == 1) ? 8 : 1024;
    endfunction

    function automatic int brev(input int a, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((a >> i) & 1);
        return r;
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            nfill[m] = 0; nrd[m] = 0; drain[m] = 0; ovf[m] = 0;
            e_rdata[m] = 0; e_rv[m] = 0; e_rl[m] = 0;
        end
    endtask

    task automatic mstep(input int m);
        int d;
        d = dep(m);
        if (clr) begin
            nfill[m] = 0; nrd[m] = 0; drain[m] = 0; ovf[m] = 0;
            e_rv[m] = 0; e_rl[m] = 0;
            return;
        end
        e_rv[m] = 0;
        e_rl[m] = 0;
        if (!drain[m]) begin
            if (wren) begin
                frame[m][nfill[m]] = int'(wdata);
                nfill[m]++;
                if (nfill[m] == d) begin
                    for (int k = 0; k < d; k++)
                        order[m][k] = frame[m][(m == 1) ? brev(k, $clog2(d)) : k];
                    nrd[m] = 0;
                    drain[m] = 1;
                end
            end
        end else begin
            if (wren) ovf[m] = 1;
            if (rden) begin
                e_rdata[m] = order[m][nrd[m]];
                e_rv[m] = 1;
                e_rl[m] = (nrd[m] == d - 1);
                nrd[m]++;
                if (nrd[m] == d) begin
                    drain[m] = 0;
                    nfill[m] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) if (rst_n) begin mstep(0); mstep(1); end
    always @(negedge rst_n) mreset();

    task automatic cmp(input int m, input logic [31:0] rd, input logic [31:0] rv,
                       input logic [31:0] rl, input logic [31:0] fu, input logic [31:0] em,
                       input logic [31:0] cn, input logic [31:0] ov);
        string p;
        int c;
        p = (m == 1) ? "rev" : "nat";
        c = drain[m] ? dep(m) - nrd[m] : nfill[m];
        chk({p, ".rdata"}, rd, e_rdata[m]);
        chk({p, ".rvalid"}, rv, 32'(e_rv[m]));
        chk({p, ".rlast"}, rl, 32'(e_rl[m]));
        chk({p, ".full"}, fu, 32'(drain[m]));
        chk({p, ".empty"}, em, 32'(c == 0));
        chk({p, ".count"}, cn, c);
        chk({p, ".overflow"}, ov, 32'(ovf[m]));
    endtask

    bit ck_en = 0;
    always @(negedge clk) if (ck_en) begin
        cmp(0, 32'(rdata_n), 32'(rvalid_n), 32'(rlast_n), 32'(full_n), 32'(empty_n),
            32'(count_n), 32'(ovf_n));
        cmp(1, 32'(rdata_r), 32'(rvalid_r), 32'(rlast_r), 32'(full_r), 32'(empty_r),
            32'(count_r), 32'(ovf_r));
    end

    task automatic write_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wren = 1'b1;
            wdata = 14'(base + i);
        end
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    int exp_rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial begin
        int i, c, k, j, nl;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst.empty", 32'(empty_n), 1);
        chk("rst.full", 32'(full_n), 0);
        chk("rst.count", 32'(count_n), 0);
        chk("rst.rdata", 32'(rdata_n), 0);
        rst_n = 1'b1;
        ck_en = 1;

        // natural frame with a gap every third cycle
        i = 0; c = 0;
        while (i < 1024) begin
            @(negedge clk);
            if (c % 3 == 2) begin
                wren = 1'b0;
            end else begin
                wren = 1'b1;
                wdata = 14'(i);
                i++;
            end
            c++;
        end
        @(negedge clk);
        wren = 1'b0;
        chk("nat.full_after_fill", 32'(full_n), 1);
        chk("rev.overflow_sticky", 32'(ovf_r), 1);
        rden = 1'b1;
        k = 0; j = 0; nl = 0;
        for (int t = 0; t < 1030; t++) begin
            @(negedge clk);
            if (rvalid_n) begin
                chk("nat.seq", 32'(rdata_n), k);
                if (rlast_n) begin
                    nl++;
                    chk("nat.rlast_idx", k, 1023);
                end
                k++;
            end
            if (rvalid_r && j < 8) begin
                chk("rev.seq", 32'(rdata_r), exp_rev[j]);
                j++;
            end
        end
        rden = 1'b0;
        chk("nat.nread", k, 1024);
        chk("nat.nlast", nl, 1);
        chk("rev.nread", j, 8);
        chk("nat.full_end", 32'(full_n), 0);
        chk("nat.empty_end", 32'(empty_n), 1);
        pulse_clr();
        chk("rev.ovf_clr", 32'(ovf_r), 0);

        // reads during FILL are ignored
        write_n(3, 40);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            rden = 1'b1;
            chk("rev.fill_norv", 32'(rvalid_r), 0);
        end
        @(negedge clk);
        rden = 1'b0;
        chk("rev.fill_count", 32'(count_r), 3);
        write_n(5, 43);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            rden = (t % 3 == 0);
        end
        rden = 1'b0;

        // abort after three reads
        pulse_clr();
        write_n(8, 100);
        rden = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rden = 1'b0;
        chk("abort.rvalid", 32'(rvalid_r), 0);
        chk("abort.count", 32'(count_r), 0);
        chk("abort.full", 32'(full_r), 0);
        write_n(8, 200);
        rden = 1'b1;
        j = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rvalid_r) begin
                chk("abort.reread", 32'(rdata_r), 200 + exp_rev[j]);
                j++;
            end
        end
        rden = 1'b0;
        chk("abort.nread", j, 8);

        // asynchronous reset mid-fill
        pulse_clr();
        write_n(5, 300);
        chk("arst.count_pre", 32'(count_r), 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.count_r", 32'(count_r), 0);
        chk("arst.count_n", 32'(count_n), 0);
        chk("arst.empty", 32'(empty_r), 1);
        chk("arst.full", 32'(full_r), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // random traffic
        for (int t = 0; t < 2600; t++) begin
            @(negedge clk);
            wren = ($urandom_range(0, 3) != 0);
            rden = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 2999) == 0);
            wdata = 14'($urandom);
        end
        @(negedge clk);
        wren = 1'b0; rden = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        ck_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
